encoder_8x3: RTL and testbench



---
 rtl/encoder_pkg.sv | 35 +++
 rtl/prio_enc_comb.sv | 28 ++
 rtl/encoder_8x3.sv | 72 +++++++
 tb/tb_encoder_8x3.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared widths, index type and set-bit search helpers for the 8-to-3 priority encoder.
// The optional multi-hot flag is built only when ENCODER_MULTI_HOT_EN is defined.
package encoder_pkg;

   localparam int unsigned ENC_IN_W  = 8;
   localparam int unsigned ENC_OUT_W = 3;

   typedef logic [ENC_OUT_W-1:0] enc_idx_t;
   typedef logic [ENC_IN_W-1:0]  enc_vec_t;

   // Index of the winning set bit; returns 0 for an all-zero vector.
   // The scan direction makes the last hit in the loop the winner.
   function automatic enc_idx_t find_set_idx(input enc_vec_t vec, input logic lsb_first);
      enc_idx_t idx;
      idx = '0;
      if (lsb_first) begin
         for (int i = ENC_IN_W - 1; i >= 0; i--) begin
            if (vec[i]) idx = ENC_OUT_W'(i);
         end
      end else begin
         for (int i = 0; i < ENC_IN_W; i++) begin
            if (vec[i]) idx = ENC_OUT_W'(i);
         end
      end
      return idx;
   endfunction

   // True when more than one bit is set: clearing the lowest set bit leaves something.
   function automatic logic is_multi_hot(input enc_vec_t vec);
      enc_vec_t low_cleared;
      low_cleared = vec & (vec - ENC_IN_W'(1));
      return (low_cleared != '0);
   endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational priority search: winning index, any-set and (optionally) multi-set.
// Multi-set logic and its port exist only under ENCODER_MULTI_HOT_EN.
module prio_enc_comb
   import encoder_pkg::*;
(
   input  enc_vec_t i_vec,
   input  logic     i_lsb_first,
   output enc_idx_t o_idx_c,
`ifdef ENCODER_MULTI_HOT_EN
   output logic     o_multi_c,
`endif
   output logic     o_any_c
);

   // Index and occupancy of the request vector.
   always_comb begin
      o_idx_c = find_set_idx(i_vec, i_lsb_first);
      o_any_c = (i_vec != '0);
   end

`ifdef ENCODER_MULTI_HOT_EN
   // More than one request present.
   always_comb begin
      o_multi_c = is_multi_hot(i_vec);
   end
`endif

endmodule

// File: rtl/encoder_8x3.sv
// 8-to-3 priority encoder with enable and one-cycle registered result.
// LSB_PRIORITY=0 picks the highest set bit, 1 picks the lowest.
// Define ENCODER_MULTI_HOT_EN to add the registered 'multi' output.
module encoder_8x3
   import encoder_pkg::*;
#(
   parameter int unsigned LSB_PRIORITY = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ENC_IN_W-1:0]  In,
   input  logic                 En,
   output logic [ENC_OUT_W-1:0] out,
`ifdef ENCODER_MULTI_HOT_EN
   output logic                 multi,
`endif
   output logic                 valid
);

   localparam logic LSB_FIRST = (LSB_PRIORITY != 0);

   enc_idx_t w_idx;
   logic     w_any;
   enc_idx_t r_out;
   logic     r_valid;

`ifdef ENCODER_MULTI_HOT_EN
   logic     w_multi;
   logic     r_multi;
`endif

   prio_enc_comb u_prio (
      .i_vec       (In),
      .i_lsb_first (LSB_FIRST),
      .o_idx_c     (w_idx),
`ifdef ENCODER_MULTI_HOT_EN
      .o_multi_c   (w_multi),
`endif
      .o_any_c     (w_any)
   );

   // Result register: reset wins, then a result only when enabled with a request present.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out   <= '0;
         r_valid <= 1'b0;
      end else if (En && w_any) begin
         r_out   <= w_idx;
         r_valid <= 1'b1;
      end else begin
         r_out   <= '0;
         r_valid <= 1'b0;
      end
   end

`ifdef ENCODER_MULTI_HOT_EN
   // Multi-hot flag register, qualified by enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_multi <= 1'b0;
      end else begin
         r_multi <= En && w_multi;
      end
   end

   assign multi = r_multi;
`endif

   assign out   = r_out;
   assign valid = r_valid;

endmodule

// File: tb/tb_encoder_8x3.sv
// Directed self-checking bench: one MSB-priority and one LSB-priority instance share stimulus.
module tb_encoder_8x3;

   logic       clk;
   logic       rst;
   logic [7:0] In;
   logic       En;
   logic [2:0] out_m;
   logic       valid_m;
   logic [2:0] out_l;
   logic       valid_l;
`ifdef ENCODER_MULTI_HOT_EN
   logic       multi_m;
   logic       multi_l;
`endif

   int n_checks;
   int n_fail;

   encoder_8x3 #(.LSB_PRIORITY(0)) u_dut_msb (
      .clk   (clk),
      .rst   (rst),
      .In    (In),
      .En    (En),
      .out   (out_m),
`ifdef ENCODER_MULTI_HOT_EN
      .multi (multi_m),
`endif
      .valid (valid_m)
   );

   encoder_8x3 #(.LSB_PRIORITY(1)) u_dut_lsb (
      .clk   (clk),
      .rst   (rst),
      .In    (In),
      .En    (En),
      .out   (out_l),
`ifdef ENCODER_MULTI_HOT_EN
      .multi (multi_l),
`endif
      .valid (valid_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle; inputs applied before the call are sampled on this edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_both(input string tag, input logic [2:0] exp_m, input logic [2:0] exp_l,
                             input logic exp_v);
      check({tag, " out_msb"},   8'(out_m),   8'(exp_m));
      check({tag, " valid_msb"}, 8'(valid_m), 8'(exp_v));
      check({tag, " out_lsb"},   8'(out_l),   8'(exp_l));
      check({tag, " valid_lsb"}, 8'(valid_l), 8'(exp_v));
   endtask

   logic [7:0] seq_in   [8];
   logic [2:0] seq_msb  [8];
   logic [2:0] seq_lsb  [8];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      seq_in   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      seq_msb  = '{3'd0,  3'd1,  3'd1,  3'd2,  3'd2,  3'd2,  3'd2,  3'd3};
      seq_lsb  = '{3'd0,  3'd1,  3'd0,  3'd2,  3'd0,  3'd1,  3'd0,  3'd3};

      // Reset held two cycles with a full request vector enabled.
      rst = 1'b1; En = 1'b1; In = 8'hFF;
      step();
      check_both("reset1", 3'd0, 3'd0, 1'b0);
`ifdef ENCODER_MULTI_HOT_EN
      check("reset1 multi", 8'(multi_m), 8'd0);
`endif
      step();
      check_both("reset2", 3'd0, 3'd0, 1'b0);

      // Incrementing vectors, one result per edge.
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         In = seq_in[i];
         step();
         check_both($sformatf("seq_%0h", seq_in[i]), seq_msb[i], seq_lsb[i], 1'b1);
      end

      // All bits set: extremes of each priority direction.
      In = 8'hFF;
      step();
      check_both("all_ff", 3'd7, 3'd0, 1'b1);

      // Enabled with no request, then disabled with a request.
      In = 8'h00;
      step();
      check_both("zero_in", 3'd0, 3'd0, 1'b0);
      En = 1'b0; In = 8'h80;
      step();
      check_both("disabled", 3'd0, 3'd0, 1'b0);

      // Priority direction distinguishing vectors.
      En = 1'b1; In = 8'h06;
      step();
      check_both("in_06", 3'd2, 3'd1, 1'b1);
      In = 8'hF0;
      step();
      check_both("in_f0", 3'd7, 3'd4, 1'b1);
      In = 8'h80;
      step();
      check_both("in_80", 3'd7, 3'd7, 1'b1);

      // Mid-stream reset pulse, then recovery on the first edge after release.
      rst = 1'b1;
      step();
      check_both("mid_reset", 3'd0, 3'd0, 1'b0);
      rst = 1'b0;
      step();
      check_both("post_reset", 3'd7, 3'd7, 1'b1);

`ifdef ENCODER_MULTI_HOT_EN
      In = 8'h03;
      step();
      check("multi_03 msb", 8'(multi_m), 8'd1);
      check("multi_03 lsb", 8'(multi_l), 8'd1);
      In = 8'h04;
      step();
      check("multi_04 msb", 8'(multi_m), 8'd0);
      check("multi_04 out", 8'(out_m),   8'd2);
      In = 8'h03; En = 1'b0;
      step();
      check("multi_dis msb", 8'(multi_m), 8'd0);
      check("multi_dis lsb", 8'(multi_l), 8'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
